mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_shift_core.sv | 67 ++++++
 rtl/mul_div_unit.sv | 127 ++++++++++++
 tb/tb_mul_div_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared op encodings, FSM states and sizing helpers for the MDU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam int MDU_WIDTH_DEFAULT = 32;
  localparam int CNT_W = $clog2(MDU_WIDTH_DEFAULT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } mdu_state_t;

  function automatic int mdu_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_shift_core.sv
// ============================================================================
// Module : mdu_shift_core
// Brief  : 2W accumulator performing one shift-add or restoring-divide step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_shift_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = mdu_cnt_w(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Multiply: low half holds the multiplier, consumed LSB first.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

  // Divide: W+1-bit trial; quotient bit set when the subtract does not borrow.
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_qbit    = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_nxt = w_qbit ? (w_rem_sh[WIDTH-1:0] - r_opb) : w_rem_sh[WIDTH-1:0];

  assign w_acc_nxt = is_div ? {w_rem_nxt, r_acc[WIDTH-2:0], w_qbit}
                            : {w_mul_sum, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
      r_opb <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_acc <= {{WIDTH{1'b0}}, opa};
      r_opb <= opb;
      r_cnt <= CW'(WIDTH);
    end else if (step) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign acc  = r_acc;
  assign last = (r_cnt == CW'(1));

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module : mul_div_unit
// Brief  : Iterative MULT/DIV unit with architectural HI/LO and MTHI/MTLO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t r_state, w_state_nxt;

  logic             r_is_div;
  logic             r_neg_ab;
  logic             r_neg_a;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic               w_idle;
  logic               w_accept;
  logic               w_op_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH-1:0]   w_opb;
  logic               w_step;
  logic               w_last;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle && start && (op[2] == 1'b0);
  assign w_op_signed = SIGNED_EN && op[0];
  assign w_a_neg     = w_op_signed && a[WIDTH-1];
  assign w_b_neg     = w_op_signed && b[WIDTH-1];
  assign w_opa       = w_a_neg ? -a : a;
  assign w_opb       = w_b_neg ? -b : b;
  assign w_step      = (r_state == ST_CALC);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_CALC;
      ST_CALC:   if (w_last)   w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  mdu_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (w_accept),
    .step   (w_step),
    .is_div (r_is_div),
    .opa    (w_opa),
    .opb    (w_opb),
    .acc    (w_acc),
    .last   (w_last)
  );

  // Magnitude results are sign-corrected only when written to HI/LO.
  assign w_prod = r_neg_ab ? -w_acc : w_acc;
  assign w_quo  = r_neg_ab ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
  assign w_rem  = r_neg_a  ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_ab <= 1'b0;
      r_neg_a  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_FINISH);
      if (w_accept) begin
        r_is_div <= op[1];
        r_neg_ab <= w_a_neg ^ w_b_neg;
        r_neg_a  <= w_a_neg;
      end
      if (r_state == ST_FINISH) begin
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end else if (w_idle && start && (op == MDU_MTHI)) begin
        r_hi <= a;
      end else if (w_idle && start && (op == MDU_MTLO)) begin
        r_lo <= a;
      end
    end
  end

  assign busy = !w_idle;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module : tb_mul_div_unit
// Brief  : Directed bench with an arithmetic reference model for mul_div_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  localparam int W = 32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic        busy_u, done_u;
  logic [31:0] hi_u, lo_u;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_nosign (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy_u), .done(done_u), .hi(hi_u), .lo(lo_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic with the architectural corner rules.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p, qv, rv;
    longint sa, sb;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    p  = '0;
    case (o)
      3'd0: p = {32'b0, x} * {32'b0, y};
      3'd1: p = sa * sb;
      3'd2: p = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      3'd3: begin
        if (y == 0) begin
          p = {x, (sa < 0) ? 32'h00000001 : 32'hFFFFFFFF};
        end else begin
          qv = sa / sb;
          rv = sa % sb;
          p  = {rv[31:0], qv[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Cycle compare against the model, one sample per clock just after the edge.
  initial begin
    logic        s_rst, s_start, m_done, m_live;
    logic [2:0]  s_op;
    logic [31:0] s_a, s_b, m_hi, m_lo, p_hi, p_lo;
    int          m_cnt;
    m_live = 1'b0; m_cnt = 0; m_done = 1'b0;
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
    forever begin
      @(posedge clk);
      s_rst = reset; s_start = start; s_op = op; s_a = a; s_b = b;
      #1;
      if (!s_rst) begin
        m_live = 1'b1; m_cnt = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
      end else if (m_live) begin
        m_done = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end else if (s_start) begin
          if (s_op <= 3'd3) begin
            {p_hi, p_lo} = model(s_op, s_a, s_b);
            m_cnt = W + 1;
          end else if (s_op == 3'd4) begin
            m_hi = s_a;
          end else if (s_op == 3'd5) begin
            m_lo = s_a;
          end
        end
      end
      if (m_live) begin
        chk32("cyc_busy", {31'b0, busy}, {31'b0, (m_cnt > 0)});
        chk32("cyc_done", {31'b0, done}, {31'b0, m_done});
        chk32("cyc_hi", hi, m_hi);
        chk32("cyc_lo", lo, m_lo);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Waits (bounded) for done; counts busy cycles from the accept edge onward.
  task automatic wait_done(output int bcyc, output int seen);
    bcyc = busy ? 1 : 0;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bcyc++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int bc, sd;
    issue(o, x, y);
    wait_done(bc, sd);
    chk32({name, "_done_seen"}, sd, 1);
    chk32({name, "_hi"}, hi, ehi);
    chk32({name, "_lo"}, lo, elo);
  endtask

  initial begin
    int bc, sd, dcount;
    reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk32("rst_busy", {31'b0, busy}, 0);
    chk32("rst_done", {31'b0, done}, 0);
    chk32("rst_hi", hi, 0);
    chk32("rst_lo", lo, 0);

    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(bc, sd);
    chk32("multu_busy_cycles", bc, 33);
    chk32("multu_done_seen", sd, 1);
    chk32("multu_hi", hi, 32'hFFFFFFFE);
    chk32("multu_lo", lo, 32'h00000001);
    @(negedge clk);
    chk32("multu_done_once", {31'b0, done}, 0);

    run("mult_neg", 3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    chk32("mult_nosign_hi", hi_u, 32'h00000004);
    chk32("mult_nosign_lo", lo_u, 32'hFFFFFFF1);
    run("mult_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run("div_neg", 3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("div_negb", 3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run("divu", 3'd2, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
    run("divu_big", 3'd2, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
    run("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run("divu_zero", 3'd2, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
    run("div_zero", 3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001);

    // MTHI during busy is dropped; MTHI in the done cycle lands.
    issue(3'd0, 32'h00010000, 32'h00010000);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h00001234;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, sd);
    chk32("mthi_busy_done_seen", sd, 1);
    chk32("mthi_busy_hi", hi, 32'h00000001);
    chk32("mthi_busy_lo", lo, 32'h00000000);
    start = 1'b1; op = 3'd4; a = 32'h00001234;
    @(negedge clk);
    start = 1'b0;
    chk32("mthi_done_hi", hi, 32'h00001234);
    chk32("mthi_done_lo", lo, 32'h00000000);
    chk32("mthi_done_busy", {31'b0, busy}, 0);
    chk32("mthi_done_done", {31'b0, done}, 0);
    run("undef_op_guard", 3'd0, 32'h00000003, 32'h00000003, 32'h00000000, 32'h00000009);
    @(negedge clk);
    start = 1'b1; op = 3'd7; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    chk32("undef_busy", {31'b0, busy}, 0);
    chk32("undef_hi", hi, 32'h00000000);

    // Reset at edge 10 of a DIVU aborts it.
    issue(3'd2, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk32("abort_busy", {31'b0, busy}, 0);
    chk32("abort_done", {31'b0, done}, 0);
    chk32("abort_hi", hi, 0);
    chk32("abort_lo", lo, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk32("abort_no_done", dcount, 0);
    run("post_reset_mul", 3'd0, 32'd6, 32'd7, 32'h00000000, 32'h0000002A);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
